fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC, NPC and memory address.
REQ-002 Parameter DATA_W, default 32, width of fetched instruction word.
REQ-003 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-004 Parameter PC_STEP, default 4, PC increment per fetch; power of two, at least 1.
REQ-005 Parameter TIMEOUT, default 15, maximum WAIT cycles without MOC before fault; at least 1.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 fetch_req  input  1  decode side requests the next instruction.
REQ-009 stall  input  1  blocks start of a new fetch while high.
REQ-010 redirect_valid  input  1  branch/jump redirect request.
REQ-011 redirect_target  input  ADDR_W  new PC for a redirect.
REQ-012 MOC  input  1  memory operation complete, level-sampled.
REQ-013 mem_data  input  DATA_W  memory read data, valid when MOC=1.
REQ-014 mem_addr  output  ADDR_W  registered memory address (MAR).
REQ-015 mem_enable  output  1  registered memory request strobe.
REQ-016 mem_rw  output  1  constant 0 (read).
REQ-017 ir  output  DATA_W  instruction register.
REQ-018 ir_valid  output  1  one-cycle pulse, ir holds a new instruction.
REQ-019 pc  output  ADDR_W  current program counter.
REQ-020 npc  output  ADDR_W  address following the last delivered instruction.
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 fault  output  1  sticky error flag.

Function
REQ-023 FSM states IDLE, ADDR, WAIT, DONE, FAULT; all outputs registered except busy (decode of state).
REQ-024 IDLE: redirect_valid=1 -> pc<=redirect_target, stay IDLE; redirect has priority over fetch_req in the same cycle.
REQ-025 IDLE: fetch_req=1, stall=0, redirect_valid=0 -> mem_addr<=pc, go ADDR; stall=1 holds IDLE.
REQ-026 ADDR: mem_enable<=1, wait counter<=0, go WAIT.
REQ-027 WAIT, MOC=1: mem_enable<=0, ir<=mem_data, pc<=pc+PC_STEP, npc<=pc+PC_STEP, ir_valid<=1, go DONE.
REQ-028 WAIT, MOC=0: counter increments; counter reaching TIMEOUT -> mem_enable<=0, fault<=1, go FAULT.
REQ-029 DONE: ir_valid<=0, go IDLE; fetch_req ignored; minimum fetch period 4 cycles, minimum fetch_req-to-ir_valid latency 3 cycles.
REQ-030 redirect_valid in ADDR or WAIT: target captured into pending register (last one wins); on MOC, ir and ir_valid unchanged (fetch discarded), pc<=pending target, npc unchanged, go DONE.
REQ-031 redirect_valid coincident with MOC in WAIT: treated as pending redirect per REQ-030.
REQ-032 redirect_valid in DONE: applied as in IDLE (pc<=redirect_target), overriding the increment just taken.
REQ-033 Redirect target with any bit of (PC_STEP-1) set: fault<=1, go FAULT, pc unchanged.
REQ-034 pc+PC_STEP wraps modulo 2^ADDR_W; no fault on wrap.
REQ-035 FAULT: mem_enable=0, ir_valid=0, all inputs ignored until reset.
REQ-036 MOC high outside WAIT ignored.

Reset
REQ-037 reset=1 at a clock edge: state<=IDLE, pc<=RESET_VECTOR, npc<=RESET_VECTOR, mem_addr<=0, mem_enable<=0, ir<=0, ir_valid<=0, fault<=0, pending redirect cleared, counter<=0.
REQ-038 Reset mid-fetch (ADDR/WAIT/DONE) aborts the fetch with no ir update; reset overrides all other inputs.

Verification
REQ-039 Reset, fetch_req=1, MOC one cycle after mem_enable, mem_data=0x20080005 -> ir=0x20080005, ir_valid pulse 1 cycle, pc=npc=4, 3-cycle latency.
REQ-040 pc=0x8, redirect_valid=1 target 0x40 in IDLE with fetch_req=1 -> pc=0x40, next fetch mem_addr=0x40, pc after fetch=0x44.
REQ-041 Redirect target 0x100 during WAIT, then MOC -> no ir_valid, ir unchanged, pc=0x100.
REQ-042 MOC never asserted -> fault=1 after exactly TIMEOUT WAIT cycles, mem_enable=0; further fetch_req ignored until reset.
REQ-043 ADDR_W=8, RESET_VECTOR=0xFC, PC_STEP=4 -> after one fetch pc=0x00, fault=0; redirect target 0x02 -> fault=1.
REQ-044 reset asserted in WAIT with MOC=1 -> state IDLE, ir=0, ir_valid=0, pc=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Memory-side bus of the fetch sequencer: registered address/strobe out,
// completion flag and read data back.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_rw;
  logic              MOC;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_addr, mem_enable, mem_rw,
    input  MOC, mem_data
  );

  modport slave (
    input  mem_addr, mem_enable, mem_rw,
    output MOC, mem_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> ADDR -> WAIT -> DONE per fetch, with
// redirect handling, alignment checking and a WAIT-cycle timeout fault.
module fetch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                PC_STEP      = 4,
  parameter int                TIMEOUT      = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_target,
  fetch_sequencer_if.master      mem,
  output logic [DATA_W-1:0]      ir,
  output logic                   ir_valid,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      npc,
  output logic                   busy,
  output logic                   fault
);

  localparam int                CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              men_q, men_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              irv_q, irv_d;
  logic              fault_q, fault_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              misaligned;

  assign misaligned = (redirect_target & STEP_MASK) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      npc_q      <= RESET_VECTOR;
      mar_q      <= '0;
      men_q      <= 1'b0;
      ir_q       <= '0;
      irv_q      <= 1'b0;
      fault_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      mar_q      <= mar_d;
      men_q      <= men_d;
      ir_q       <= ir_d;
      irv_q      <= irv_d;
      fault_q    <= fault_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    mar_d      = mar_q;
    men_d      = men_q;
    ir_d       = ir_q;
    irv_d      = irv_q;
    fault_d    = fault_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (fetch_req && !stall) begin
          mar_d   = pc_q;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        men_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
        if (redirect_valid) begin
          if (misaligned) begin
            men_d   = 1'b0;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_target;
          end
        end
      end

      S_WAIT: begin
        if (redirect_valid && misaligned) begin
          men_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else if (mem.MOC) begin
          // A redirect arriving with MOC wins over an older pending one.
          men_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = S_DONE;
          if (redirect_valid) begin
            pc_d = redirect_target;
          end else if (pend_q) begin
            pc_d = pend_tgt_q;
          end else begin
            ir_d  = mem.mem_data;
            pc_d  = pc_q + STEP;
            npc_d = pc_q + STEP;
            irv_d = 1'b1;
          end
        end else begin
          if (redirect_valid) begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_target;
          end
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            men_d   = 1'b0;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        irv_d   = 1'b0;
        state_d = S_IDLE;
        if (redirect_valid) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d = redirect_target;
          end
        end
      end

      S_FAULT: begin
        men_d = 1'b0;
        irv_d = 1'b0;
      end

      default: state_d = S_FAULT;
    endcase
  end

  assign mem.mem_addr   = mar_q;
  assign mem.mem_enable = men_q;
  assign mem.mem_rw     = 1'b0;
  assign ir             = ir_q;
  assign ir_valid       = irv_q;
  assign pc             = pc_q;
  assign npc            = npc_q;
  assign fault          = fault_q;
  assign busy           = state_q != S_IDLE;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default 32-bit instance and an
// 8-bit instance starting at 0xFC for the wrap/alignment cases.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        fetch_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] ir, pc, npc;
  logic        ir_valid, busy, fault;

  logic        fetch_req1 = 1'b0;
  logic        redirect_valid1 = 1'b0;
  logic [7:0]  redirect_target1 = '0;
  logic [31:0] ir1;
  logic [7:0]  pc1, npc1;
  logic        ir_valid1, busy1, fault1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
  fetch_sequencer_if #(.ADDR_W(8),  .DATA_W(32)) m1 ();

  fetch_sequencer u0 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .mem(m0.master), .ir(ir), .ir_valid(ir_valid), .pc(pc), .npc(npc),
    .busy(busy), .fault(fault)
  );

  fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_VECTOR(8'hFC),
                    .PC_STEP(4), .TIMEOUT(15)) u1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req1), .stall(stall),
    .redirect_valid(redirect_valid1), .redirect_target(redirect_target1),
    .mem(m1.master), .ir(ir1), .ir_valid(ir_valid1), .pc(pc1), .npc(npc1),
    .busy(busy1), .fault(fault1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] data);
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    m0.MOC = 1'b1; m0.mem_data = data; tick();
    m0.MOC = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (npc !== 32'h0) begin failures++; $display("FAIL reset_npc got=%h exp=%h", npc, 32'h0); end
    checks++; if (m0.mem_enable !== 1'b0 || m0.mem_addr !== 32'h0 || m0.mem_rw !== 1'b0) begin
      failures++; $display("FAIL reset_mem got=%b/%h/%b exp=0/0/0", m0.mem_enable, m0.mem_addr, m0.mem_rw); end
    checks++; if (ir !== 32'h0 || ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir got=%h/%b exp=0/0", ir, ir_valid); end
    checks++; if (fault !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", fault, busy); end
    checks++; if (pc1 !== 8'hFC) begin failures++; $display("FAIL reset_pc1 got=%h exp=fc", pc1); end
  endtask

  task automatic test_basic_fetch();
    fetch_req = 1'b1; tick();
    checks++; if (busy !== 1'b1 || m0.mem_addr !== 32'h0 || m0.mem_enable !== 1'b0) begin
      failures++; $display("FAIL basic_addr got=%b/%h/%b exp=1/0/0", busy, m0.mem_addr, m0.mem_enable); end
    fetch_req = 1'b0; tick();
    checks++; if (m0.mem_enable !== 1'b1 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL basic_enable got=%b/%b exp=1/0", m0.mem_enable, ir_valid); end
    m0.MOC = 1'b1; m0.mem_data = 32'h20080005; tick();
    checks++; if (ir_valid !== 1'b1 || ir !== 32'h20080005) begin
      failures++; $display("FAIL basic_ir got=%b/%h exp=1/20080005", ir_valid, ir); end
    checks++; if (pc !== 32'h4 || npc !== 32'h4 || m0.mem_enable !== 1'b0) begin
      failures++; $display("FAIL basic_pc got=%h/%h/%b exp=4/4/0", pc, npc, m0.mem_enable); end
    m0.MOC = 1'b0; tick();
    checks++; if (ir_valid !== 1'b0 || busy !== 1'b0 || ir !== 32'h20080005) begin
      failures++; $display("FAIL basic_done got=%b/%b/%h exp=0/0/20080005", ir_valid, busy, ir); end
  endtask

  task automatic test_back_to_back();
    fetch_req = 1'b1; tick(); tick();
    m0.MOC = 1'b1; m0.mem_data = 32'hA5A5A5A5; tick();
    m0.MOC = 1'b0; tick();
    checks++; if (busy !== 1'b0 || pc !== 32'h8) begin
      failures++; $display("FAIL b2b_done_ignores_req got=%b/%h exp=0/8", busy, pc); end
    tick();
    checks++; if (busy !== 1'b1 || m0.mem_addr !== 32'h8) begin
      failures++; $display("FAIL b2b_second_addr got=%b/%h exp=1/8", busy, m0.mem_addr); end
    fetch_req = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; fetch_req = 1'b1; m0.MOC = 1'b1; m0.mem_data = 32'h77;
    tick(); tick();
    checks++; if (busy !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0) begin
      failures++; $display("FAIL stall_hold got=%b/%b/%h exp=0/0/0", busy, ir_valid, ir); end
    stall = 1'b0; fetch_req = 1'b0; m0.MOC = 1'b0; tick();
  endtask

  task automatic test_redirect_idle();
    do_reset();
    run_fetch(32'h1); run_fetch(32'h2);
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL redir_idle_pre got=%h exp=8", pc); end
    redirect_valid = 1'b1; redirect_target = 32'h40; fetch_req = 1'b1; tick();
    checks++; if (pc !== 32'h40 || busy !== 1'b0) begin
      failures++; $display("FAIL redir_idle_pc got=%h/%b exp=40/0", pc, busy); end
    redirect_valid = 1'b0; tick();
    checks++; if (m0.mem_addr !== 32'h40 || busy !== 1'b1) begin
      failures++; $display("FAIL redir_idle_addr got=%h/%b exp=40/1", m0.mem_addr, busy); end
    fetch_req = 1'b0; tick();
    m0.MOC = 1'b1; m0.mem_data = 32'h11111111; tick();
    m0.MOC = 1'b0;
    checks++; if (pc !== 32'h44 || npc !== 32'h44) begin
      failures++; $display("FAIL redir_idle_post got=%h/%h exp=44/44", pc, npc); end
    tick();
  endtask

  task automatic test_redirect_wait();
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    redirect_valid = 1'b1; redirect_target = 32'h100; tick();
    redirect_valid = 1'b0; m0.MOC = 1'b1; m0.mem_data = 32'hDEADBEEF; tick();
    m0.MOC = 1'b0;
    checks++; if (ir_valid !== 1'b0 || ir !== 32'h11111111) begin
      failures++; $display("FAIL redir_wait_ir got=%b/%h exp=0/11111111", ir_valid, ir); end
    checks++; if (pc !== 32'h100 || npc !== 32'h44 || m0.mem_enable !== 1'b0) begin
      failures++; $display("FAIL redir_wait_pc got=%h/%h/%b exp=100/44/0", pc, npc, m0.mem_enable); end
    tick();
  endtask

  task automatic test_redirect_moc();
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    redirect_valid = 1'b1; redirect_target = 32'h200;
    m0.MOC = 1'b1; m0.mem_data = 32'hCAFEF00D; tick();
    redirect_valid = 1'b0; m0.MOC = 1'b0;
    checks++; if (ir_valid !== 1'b0 || ir !== 32'h11111111 || pc !== 32'h200) begin
      failures++; $display("FAIL redir_moc got=%b/%h/%h exp=0/11111111/200", ir_valid, ir, pc); end
    tick();
  endtask

  task automatic test_redirect_done();
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    m0.MOC = 1'b1; m0.mem_data = 32'h33; tick();
    m0.MOC = 1'b0;
    checks++; if (ir_valid !== 1'b1 || pc !== 32'h204) begin
      failures++; $display("FAIL redir_done_pre got=%b/%h exp=1/204", ir_valid, pc); end
    redirect_valid = 1'b1; redirect_target = 32'h300; tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'h300 || npc !== 32'h204 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL redir_done_pc got=%h/%h/%b exp=300/204/0", pc, npc, ir_valid); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h102; tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || pc !== 32'h300 || busy !== 1'b1) begin
      failures++; $display("FAIL misaligned got=%b/%h/%b exp=1/300/1", fault, pc, busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL timeout_reset got=%b exp=0", fault); end
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (fault !== 1'b0 || m0.mem_enable !== 1'b1) begin
      failures++; $display("FAIL timeout_early got=%b/%b exp=0/1", fault, m0.mem_enable); end
    tick();
    checks++; if (fault !== 1'b1 || m0.mem_enable !== 1'b0) begin
      failures++; $display("FAIL timeout_fault got=%b/%b exp=1/0", fault, m0.mem_enable); end
    fetch_req = 1'b1; m0.MOC = 1'b1; m0.mem_data = 32'h99;
    redirect_valid = 1'b1; redirect_target = 32'h80;
    for (int i = 0; i < 5; i++) tick();
    fetch_req = 1'b0; m0.MOC = 1'b0; redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || busy !== 1'b1 || m0.mem_enable !== 1'b0 || ir_valid !== 1'b0 || pc !== 32'h0 || ir !== 32'h0) begin
      failures++; $display("FAIL fault_sticky got=%b/%b/%b/%b/%h/%h exp=1/1/0/0/0/0",
                           fault, busy, m0.mem_enable, ir_valid, pc, ir); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h40; tick();
    redirect_valid = 1'b0;
    run_fetch(32'h55);
    fetch_req = 1'b1; tick();
    fetch_req = 1'b0; tick();
    m0.MOC = 1'b1; m0.mem_data = 32'h66; reset = 1'b1; tick();
    reset = 1'b0; m0.MOC = 1'b0;
    checks++; if (busy !== 1'b0 || ir !== 32'h0 || ir_valid !== 1'b0 || pc !== 32'h0 || m0.mem_enable !== 1'b0) begin
      failures++; $display("FAIL reset_wait got=%b/%h/%b/%h/%b exp=0/0/0/0/0",
                           busy, ir, ir_valid, pc, m0.mem_enable); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_req1 = 1'b1; tick();
    checks++; if (m1.mem_addr !== 8'hFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fc", m1.mem_addr); end
    fetch_req1 = 1'b0; tick();
    m1.MOC = 1'b1; m1.mem_data = 32'h0BADC0DE; tick();
    m1.MOC = 1'b0;
    checks++; if (pc1 !== 8'h00 || npc1 !== 8'h00 || fault1 !== 1'b0 || ir_valid1 !== 1'b1 || ir1 !== 32'h0BADC0DE) begin
      failures++; $display("FAIL wrap_pc got=%h/%h/%b/%b/%h exp=00/00/0/1/0badc0de", pc1, npc1, fault1, ir_valid1, ir1); end
    tick();
    redirect_valid1 = 1'b1; redirect_target1 = 8'h02; tick();
    redirect_valid1 = 1'b0;
    checks++; if (fault1 !== 1'b1 || pc1 !== 8'h00) begin
      failures++; $display("FAIL wrap_misaligned got=%b/%h exp=1/00", fault1, pc1); end
  endtask

  initial begin
    m0.MOC = 1'b0; m0.mem_data = '0;
    m1.MOC = 1'b0; m1.mem_data = '0;
    tick();
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_stall();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_moc();
    test_redirect_done();
    test_misaligned();
    test_timeout();
    test_reset_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
